// File: rtl/mem_line_responder.sv
// Line-granular backing store behind the cache miss interface: an in-order request
// FIFO feeding a fixed-latency access FSM that returns one full line per request.
module mem_line_responder #(
  parameter int LINE_WORD_NUM = 8,
  parameter int LINE_NUM      = 1024,
  parameter int TAG_NUM       = 2,
  parameter int QUEUE_DEPTH   = 4,
  parameter int LATENCY       = 4,
  localparam int TAG_W  = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1,
  localparam int LINE_W = LINE_WORD_NUM * 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_is_write,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [LINE_W-1:0] rsp_data
);
  localparam int OFF_W = $clog2(LINE_WORD_NUM * 4);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [LINE_W-1:0] mem     [LINE_NUM];
  logic              q_we    [QUEUE_DEPTH];
  logic [IDX_W-1:0]  q_idx   [QUEUE_DEPTH];
  logic [TAG_W-1:0]  q_tag   [QUEUE_DEPTH];
  logic [LINE_W-1:0] q_wdata [QUEUE_DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  state_t            state;
  logic [LAT_W-1:0]  wait_cnt;
  logic              cur_we;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic [LINE_W-1:0] cur_wdata;

  logic             push, pop, access, fifo_nonempty;
  logic [IDX_W-1:0] req_idx;
  logic             unused_addr_bits;

  // Offset bits select a byte within the line and high bits alias onto the array.
  assign req_idx          = req_addr[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{req_addr[OFF_W-1:0], req_addr[31:OFF_W+IDX_W]};

  assign fifo_nonempty = (count != '0);
  assign push          = req_valid && req_ready;
  // The head leaves either from IDLE or straight out of a completing response.
  assign pop           = fifo_nonempty &&
                         ((state == S_IDLE) || (state == S_RESP && rsp_ready));
  assign access        = (state == S_WAIT) && (wait_cnt == '0);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (!push && pop) count_next = count - CNT_W'(1);
  end

  // NOTE: storage arrays carry no reset; line contents survive reset and the arrays map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      q_we[wr_ptr]    <= req_we;
      q_idx[wr_ptr]   <= req_idx;
      q_tag[wr_ptr]   <= req_tag;
      q_wdata[wr_ptr] <= req_wdata;
    end
    if (access && cur_we) mem[cur_idx] <= cur_wdata;
  end

  // NOTE: non-blocking assignments in sequential blocks so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      req_ready    <= 1'b1;
      state        <= S_IDLE;
      wait_cnt     <= '0;
      cur_we       <= 1'b0;
      cur_idx      <= '0;
      cur_tag      <= '0;
      cur_wdata    <= '0;
      rsp_valid    <= 1'b0;
      rsp_is_write <= 1'b0;
      rsp_tag      <= '0;
      rsp_data     <= '0;
    end else begin
      count     <= count_next;
      req_ready <= (count_next != CNT_W'(QUEUE_DEPTH));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        cur_we    <= q_we[rd_ptr];
        cur_idx   <= q_idx[rd_ptr];
        cur_tag   <= q_tag[rd_ptr];
        cur_wdata <= q_wdata[rd_ptr];
        wait_cnt  <= LAT_W'(LATENCY - 1);
      end

      unique case (state)
        S_IDLE: if (pop) state <= S_WAIT;
        S_WAIT: begin
          if (access) begin
            state        <= S_RESP;
            rsp_valid    <= 1'b1;
            rsp_is_write <= cur_we;
            rsp_tag      <= cur_tag;
            rsp_data     <= cur_we ? '0 : mem[cur_idx];
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? S_WAIT : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Randomized scoreboard bench for mem_line_responder: a line-array model predicts each
// response at issue time and an independent monitor compares whatever the DUT returns.
module tb_mem_line_responder;
  localparam int LINE_WORD_NUM = 8;
  localparam int LINE_NUM      = 1024;
  localparam int TAG_NUM       = 2;
  localparam int QUEUE_DEPTH   = 4;
  localparam int LATENCY       = 4;
  localparam int TAG_W         = 1;
  localparam int LW            = LINE_WORD_NUM * 32;

  typedef struct {
    bit             we;
    bit [TAG_W-1:0] tag;
    logic [LW-1:0]  data;
    bit             lat_chk;
    int             acc_cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [LW-1:0]     req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_is_write;
  logic [TAG_W-1:0]  rsp_tag;
  logic [LW-1:0]     rsp_data;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;
  bit   rdy_force = 1'b0;
  exp_t exp_q[$];
  int   vq[$];

  logic [LW-1:0] model_mem [LINE_NUM];
  bit            written   [LINE_NUM];

  mem_line_responder #(
    .LINE_WORD_NUM(LINE_WORD_NUM), .LINE_NUM(LINE_NUM), .TAG_NUM(TAG_NUM),
    .QUEUE_DEPTH(QUEUE_DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_tag(req_tag), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_write(rsp_is_write),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rsp_ready = rand_rdy ? 1'($urandom % 2) : rdy_force;
  end

  task automatic check(input bit ok, input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  function automatic int line_of(input logic [31:0] addr);
    return int'((addr / (LINE_WORD_NUM * 4)) % LINE_NUM);
  endfunction

  // One attempt: present the request for one edge; on acceptance the model predicts the response.
  task automatic try_req(input bit we, input logic [31:0] addr, input bit [TAG_W-1:0] tag,
                         input logic [LW-1:0] wdata, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_tag = tag; req_wdata = wdata;
    acc = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (acc) begin
      e.we = we; e.tag = tag; e.lat_chk = lat; e.acc_cyc = cyc;
      if (we) begin
        model_mem[line_of(addr)] = wdata;
        written[line_of(addr)]   = 1'b1;
        e.data = '0;
      end else begin
        e.data = model_mem[line_of(addr)];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input bit [TAG_W-1:0] tag,
                        input logic [LW-1:0] wdata, input bit lat);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 200) begin
      try_req(we, addr, tag, wdata, lat, acc);
      n++;
    end
    check(acc, "req_accept_timeout", LW'(n), LW'(200));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(n < 500, "drain_timeout", LW'(exp_q.size()), '0);
  endtask

  // Monitor: compares each handshaken response with the scoreboard head and
  // requires a stalled response to hold still.
  bit               in_rsp = 1'b0;
  int               first_cyc;
  logic             h_we;
  logic [TAG_W-1:0] h_tag;
  logic [LW-1:0]    h_data;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_rsp = 1'b0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        in_rsp    = 1'b1;
        first_cyc = cyc;
        vq.push_back(cyc);
        check(exp_q.size() != 0, "unexpected_rsp", LW'(rsp_tag), '0);
      end else begin
        check(rsp_tag == h_tag && rsp_is_write == h_we && rsp_data == h_data,
              "rsp_stable", rsp_data, h_data);
      end
      h_we = rsp_is_write; h_tag = rsp_tag; h_data = rsp_data;
      if (rsp_ready) begin
        in_rsp = 1'b0;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(rsp_is_write == e.we, "rsp_is_write", LW'(rsp_is_write), LW'(e.we));
          check(rsp_tag == e.tag, "rsp_tag", LW'(rsp_tag), LW'(e.tag));
          check(rsp_data === e.data, "rsp_data", rsp_data, e.data);
          if (e.lat_chk)
            check(first_cyc - e.acc_cyc == LATENCY + 1, "latency",
                  LW'(first_cyc - e.acc_cyc), LW'(LATENCY + 1));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LW-1:0] line_a;
    bit            acc5 [5];
    bit            acc;

    for (int i = 0; i < LINE_WORD_NUM; i++) line_a[i*32 +: 32] = 32'hA0 + 32'(i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(req_ready == 1'b1, "reset_req_ready", LW'(req_ready), LW'(1));
    check(rsp_valid == 1'b0, "reset_rsp_valid", LW'(rsp_valid), '0);
    check(rsp_is_write == 1'b0, "reset_rsp_is_write", LW'(rsp_is_write), '0);
    check(rsp_tag == '0, "reset_rsp_tag", LW'(rsp_tag), '0);
    check(rsp_data == '0, "reset_rsp_data", rsp_data, '0);
    rst = 1'b0;

    // Write then read one line, each into an idle block
    rdy_force = 1'b1;
    repeat (2) @(posedge clk);
    do_req(1'b1, 32'h40, 1'b1, line_a, 1'b1);
    drain();
    do_req(1'b0, 32'h40, 1'b0, '0, 1'b1);
    drain();

    // Offset bits and high aliasing bits select the same line
    do_req(1'b0, 32'h44, 1'b1, '0, 1'b0);
    do_req(1'b0, 32'h5C, 1'b0, '0, 1'b0);
    do_req(1'b0, 32'h40 + 32'(LINE_NUM * 32), 1'b1, '0, 1'b0);
    drain();

    // Stalled response with a filling FIFO behind it
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    do_req(1'b0, 32'h40, 1'b0, '0, 1'b1);
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
    check(rsp_valid == 1'b1, "stall_rsp_valid", LW'(rsp_valid), LW'(1));
    for (int i = 0; i < 5; i++)
      try_req(1'b0, 32'h40 + 32'(i * 4), TAG_W'(i % 2), '0, 1'b0, acc5[i]);
    for (int i = 0; i < 4; i++)
      check(acc5[i] == 1'b1, "fifo_accept", LW'(acc5[i]), LW'(1));
    check(acc5[4] == 1'b0, "fifo_full_refuse", LW'(acc5[4]), '0);
    @(negedge clk);
    check(req_ready == 1'b0, "fifo_full_ready", LW'(req_ready), '0);
    repeat (10) @(negedge clk);
    rdy_force = 1'b1;
    do_req(1'b0, 32'h40, 1'b1, '0, 1'b0);
    drain();

    // Back-to-back throughput with rsp_ready held high
    repeat (2) @(posedge clk);
    vq.delete();
    do_req(1'b0, 32'h40, 1'b0, '0, 1'b1);
    do_req(1'b0, 32'h44, 1'b1, '0, 1'b0);
    do_req(1'b0, 32'h48, 1'b0, '0, 1'b0);
    drain();
    check(vq.size() == 3, "spacing_count", LW'(vq.size()), LW'(3));
    if (vq.size() == 3) begin
      check(vq[1] - vq[0] == LATENCY + 1, "spacing_01", LW'(vq[1] - vq[0]), LW'(LATENCY + 1));
      check(vq[2] - vq[1] == LATENCY + 1, "spacing_12", LW'(vq[2] - vq[1]), LW'(LATENCY + 1));
    end

    // Reset while a read is in WAIT: the read is dropped, storage survives
    repeat (2) @(posedge clk);
    do_req(1'b0, 32'h40, 1'b1, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check(rsp_valid == 1'b0, "midreset_rsp_valid", LW'(rsp_valid), '0);
    check(req_ready == 1'b1, "midreset_req_ready", LW'(req_ready), LW'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check(rsp_valid == 1'b0, "midreset_no_rsp", LW'(rsp_valid), '0);
    do_req(1'b0, 32'h40, 1'b0, '0, 1'b1);
    drain();

    // Randomized mix over a few lines with random backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int            idx;
      bit            we;
      logic [31:0]   addr;
      logic [LW-1:0] wd;
      idx  = int'($urandom % 8);
      we   = !written[idx] || ($urandom % 2 == 1);
      addr = 32'(idx * 32) + ($urandom % 32) + 32'(($urandom % 4) * LINE_NUM * 32);
      for (int w = 0; w < LINE_WORD_NUM; w++) wd[w*32 +: 32] = $urandom;
      if ($urandom % 3 == 0) @(negedge clk);
      do_req(we, addr, TAG_W'($urandom % 2), wd, 1'b0);
    end
    rand_rdy  = 1'b0;
    rdy_force = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
